scan_multiplexer_nway: RTL and testbench
========================================

Name: scan_multiplexer_nway

Overview:
- Parametrised, registered successor to the fixed 8-way combinational channel multiplexer.
- Selects one of 2**SEL_BITS channels of WIDTH bits and captures it into an output register on a sample strobe.
- Two modes:
  - Manual: the channel comes from the select input.
  - Scan: an internal pointer steps through a programmable channel window, like the ADC input sequencing in the emulated ATMega32A peripherals.
- Sits between peripheral data sources and consumers (ADC front end, port readback) that need a sampled, tagged value with a valid pulse.

Parameters:
- WIDTH, 8, bits per channel.
- SEL_BITS, 3, select width. N = 2**SEL_BITS channels. Legal range 1..5.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- data_in  input  WIDTH*N  flattened channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_BITS  manual-mode channel select.
- mode  input  1  0 = manual, 1 = scan.
- scan_first  input  SEL_BITS  first channel of the scan window.
- scan_last  input  SEL_BITS  last channel of the scan window.
- scan_restart  input  1  reloads the scan pointer with scan_first.
- sample  input  1  capture strobe, one capture per high cycle.
- out  output  WIDTH  captured channel data.
- out_valid  output  1  one-cycle pulse, the cycle after a capture.
- out_chan  output  SEL_BITS  index of the channel held in out.
- scan_done  output  1  one-cycle pulse, coincident with out_valid, when the captured channel is scan_last in scan mode.

Behaviour:
- Reset (reset_n low at a rising edge):
  - out = 0, out_valid = 0, out_chan = 0, scan_done = 0.
  - Scan pointer ptr = 0, internal mode_q = 0.
  - Reset overrides every other input in the same cycle.
- Capture timing:
  - sample high in cycle t: at the edge ending t, out <= channel c of data_in, out_chan <= c.
  - out_valid = 1 during cycle t+1 only; latency is 1.
  - Back-to-back sample gives a capture and an out_valid every cycle.
  - out and out_chan hold their value between captures.
- Manual mode (mode = 0): c = sel as sampled in cycle t. ptr does not change.
- Scan mode (mode = 1): c = effective pointer eptr.
  - eptr = scan_first if (mode & ~mode_q) or scan_restart in the current cycle; otherwise eptr = ptr.
- Pointer update at each edge while mode = 1:
  - sample high: ptr <= next(eptr).
  - sample low: ptr <= eptr.
- next(p):
  - p == scan_last: next(p) = scan_first.
  - otherwise: next(p) = (p+1) mod N.
  - When scan_first > scan_last, the window wraps through N-1 to 0.
  - When scan_first == scan_last, the same channel repeats.
- scan_done = 1 in cycle t+1 iff mode = 1 in cycle t, sample was high and c == scan_last.
- mode_q <= mode at every edge.
  - 1->0: pointer frozen; scan_done never asserts while mode = 0.
  - 0->1: restarts at scan_first.
- A pointer outside the window, after scan_first/scan_last change mid-scan, increments mod N until it reaches scan_last. No silent jump.
- Reset mid-scan: the next scan-mode entry starts at scan_first because mode_q = 0.

Optional Feature:
- Macro SCAN_MUX_PARITY_EN.
- When defined:
  - Extra output out_parity, width 1, holds the even parity (XOR reduction) of the captured word.
  - It is registered alongside out, resets to 0 and updates only on capture.
- When undefined: the port does not exist and no parity logic is generated.

Test Plan:
- Reset: hold reset_n low 2 cycles with sample = 1 -> out = 0, out_chan = 0, out_valid = 0, scan_done = 0.
- Manual capture, WIDTH = 8, SEL_BITS = 3:
  - data_in channel k = 8'h10+k; sel = 5, sample 1 cycle -> next cycle out = 8'h15, out_chan = 5, out_valid = 1 for exactly 1 cycle.
  - Then change sel to 2 with sample = 0 -> out stays 8'h15.
- Scan window:
  - scan_first = 2, scan_last = 4, mode 0->1, sample high 5 consecutive cycles -> out_chan sequence 2,3,4,2,3.
  - scan_done high only with the capture of channel 4.
- Wrapped window: scan_first = 6, scan_last = 1, sample 5 cycles -> out_chan 6,7,0,1,6; scan_done on the capture of 1.
- Restart and simultaneous events:
  - Mid-scan at pointer 3, scan_restart = 1 with sample = 1 -> captured channel = scan_first = 2, next capture = 3.
  - Mode leaving and re-entering 1 -> first capture = scan_first.
- Parity, with SCAN_MUX_PARITY_EN defined: capture 8'hA7 -> out_parity = 1; capture 8'h33 -> out_parity = 0.

Source files
------------

// File: rtl/scan_multiplexer_nway.sv
// scan_multiplexer_nway
// Registered N-way channel multiplexer (N = 2**SEL_BITS) with a manual select
// mode and a scan mode that walks a programmable, possibly wrapping, channel
// window. A capture on 'sample' produces a one-cycle out_valid pulse carrying
// the channel data and its index; scan_done flags the capture of scan_last.
//
// Optional build macro: SCAN_MUX_PARITY_EN adds a registered out_parity output
// holding the XOR reduction of the captured word.

module scan_multiplexer_nway #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WIDTH*(1<<SEL_BITS)-1:0]    data_in,
  input  logic [SEL_BITS-1:0]               sel,
  input  logic                              mode,
  input  logic [SEL_BITS-1:0]               scan_first,
  input  logic [SEL_BITS-1:0]               scan_last,
  input  logic                              scan_restart,
  input  logic                              sample,
  output logic [WIDTH-1:0]                  out,
  output logic                              out_valid,
  output logic [SEL_BITS-1:0]               out_chan,
  output logic                              scan_done
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                              out_parity
`endif
);

  logic [SEL_BITS-1:0] ptr;        // scan pointer: channel the next scan capture uses
  logic                mode_q;     // mode of the previous cycle, detects scan entry
  logic                reload;     // scan entry or explicit restart this cycle
  logic [SEL_BITS-1:0] eptr;       // effective pointer after reload
  logic [SEL_BITS-1:0] eptr_next;  // pointer after a capture at eptr
  logic [SEL_BITS-1:0] chan;       // channel captured if sample is high
  logic [WIDTH-1:0]    chan_word;  // data of that channel

  // Resolve the effective scan pointer, its successor and the selected channel.
  // NOTE: every signal here is assigned on every path, so no latch can be inferred.
  always_comb begin
    reload    = (mode && !mode_q) || scan_restart;
    eptr      = reload ? scan_first : ptr;
    // At scan_last fold back to scan_first; otherwise step mod N, which lets a
    // wrapped window (first > last) pass through N-1 to 0 and lets a pointer
    // stranded outside a changed window walk forward until it meets scan_last.
    eptr_next = (eptr == scan_last) ? scan_first : eptr + 1'b1;
    chan      = mode ? eptr : sel;
    chan_word = data_in[chan*WIDTH +: WIDTH];
  end

  // Capture register, valid/done pulses and scan pointer state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out        <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      scan_done  <= 1'b0;
      ptr        <= '0;
      mode_q     <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      mode_q    <= mode;
      out_valid <= sample;
      scan_done <= sample && mode && (chan == scan_last);
      if (sample) begin
        out      <= chan_word;
        out_chan <= chan;
`ifdef SCAN_MUX_PARITY_EN
        out_parity <= ^chan_word;
`endif
      end
      // Pointer is frozen in manual mode; in scan mode it commits any reload
      // and advances only when a capture consumed the current channel.
      if (mode) begin
        ptr <= sample ? eptr_next : eptr;
      end
    end
  end

endmodule

// File: tb/tb_scan_multiplexer_nway.sv
// Directed-vector bench for scan_multiplexer_nway (WIDTH = 8, SEL_BITS = 3).
// Channel k carries 8'h10 + k unless a test overrides it, so the expected
// out value follows from the expected channel index.

module tb_scan_multiplexer_nway;

  localparam int WIDTH    = 8;
  localparam int SEL_BITS = 3;
  localparam int N        = 1 << SEL_BITS;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [WIDTH*N-1:0]     data_in;
  logic [SEL_BITS-1:0]    sel;
  logic                   mode;
  logic [SEL_BITS-1:0]    scan_first;
  logic [SEL_BITS-1:0]    scan_last;
  logic                   scan_restart;
  logic                   sample;
  logic [WIDTH-1:0]       out;
  logic                   out_valid;
  logic [SEL_BITS-1:0]    out_chan;
  logic                   scan_done;
`ifdef SCAN_MUX_PARITY_EN
  logic                   out_parity;
`endif

  int pass_count  = 0;
  int check_count = 0;

  // Observed outputs packed as {out, out_chan, out_valid, scan_done}.
  logic [WIDTH+SEL_BITS+1:0] obs;
  logic [WIDTH+SEL_BITS+1:0] exp_v;
  assign obs = {out, out_chan, out_valid, scan_done};

  scan_multiplexer_nway #(
    .WIDTH    (WIDTH),
    .SEL_BITS (SEL_BITS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .sel          (sel),
    .mode         (mode),
    .scan_first   (scan_first),
    .scan_last    (scan_last),
    .scan_restart (scan_restart),
    .sample       (sample),
    .out          (out),
    .out_valid    (out_valid),
    .out_chan     (out_chan),
    .scan_done    (scan_done)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs set after this apply to the next cycle and
  // outputs read after it reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default_data();
    for (int k = 0; k < N; k++) data_in[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample = 1'b1; mode = 1'b0; sel = 3'd5;
    scan_first = 3'd0; scan_last = 3'd0; scan_restart = 1'b0;
    load_default_data();
    tick(); tick();
    exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
    else pass_count++;
`ifdef SCAN_MUX_PARITY_EN
    check_count++;
    if (out_parity !== 1'b0) $display("FAIL reset_parity: got %b expected 0", out_parity);
    else pass_count++;
`endif
    reset_n = 1'b1; sample = 1'b0;
    tick();
    check_count++;
    if (obs !== exp_v) $display("FAIL reset_release_idle: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

  task automatic test_manual();
    sel = 3'd5; sample = 1'b1;
    tick();
    exp_v = {8'h15, 3'd5, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL manual_capture: got %h expected %h", obs, exp_v);
    else pass_count++;
    sel = 3'd2; sample = 1'b0;
    tick();
    exp_v = {8'h15, 3'd5, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL manual_hold1: got %h expected %h", obs, exp_v);
    else pass_count++;
    tick();
    check_count++;
    if (obs !== exp_v) $display("FAIL manual_hold2: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3];
    seq = '{3'd0, 3'd7, 3'd3};
    sample = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = seq[i];
      tick();
      exp_v = {8'h10 + 8'(seq[i]), seq[i], 1'b1, 1'b0};
      check_count++;
      if (obs !== exp_v) $display("FAIL b2b_manual[%0d]: got %h expected %h", i, obs, exp_v);
      else pass_count++;
    end
    sample = 1'b0;
    tick();
    exp_v = {8'h13, 3'd3, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL b2b_end_idle: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

  task automatic test_scan_window();
    logic [2:0] seq [5];
    seq = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3};
    scan_first = 3'd2; scan_last = 3'd4; mode = 1'b1; sample = 1'b1; sel = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = {8'h10 + 8'(seq[i]), seq[i], 1'b1, seq[i] == 3'd4};
      check_count++;
      if (obs !== exp_v) $display("FAIL scan_window[%0d]: got %h expected %h", i, obs, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_wrapped_window();
    logic [2:0] seq [5];
    seq = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd6};
    mode = 1'b0; sample = 1'b0;
    tick();
    exp_v = {8'h13, 3'd3, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL wrap_mode_exit: got %h expected %h", obs, exp_v);
    else pass_count++;
    scan_first = 3'd6; scan_last = 3'd1; mode = 1'b1; sample = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = {8'h10 + 8'(seq[i]), seq[i], 1'b1, seq[i] == 3'd1};
      check_count++;
      if (obs !== exp_v) $display("FAIL wrap_window[%0d]: got %h expected %h", i, obs, exp_v);
      else pass_count++;
    end
  endtask

  // Pointer is at 7 when the window moves to 2..4: it must walk 7,0,1 first.
  task automatic test_window_change();
    logic [2:0] seq [7];
    seq = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    scan_first = 3'd2; scan_last = 3'd4; sample = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_v = {8'h10 + 8'(seq[i]), seq[i], 1'b1, seq[i] == 3'd4};
      check_count++;
      if (obs !== exp_v) $display("FAIL window_change[%0d]: got %h expected %h", i, obs, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_restart();
    // Pointer sits at 3: restart with a capture takes scan_first.
    scan_restart = 1'b1; sample = 1'b1;
    tick();
    exp_v = {8'h12, 3'd2, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL restart_capture: got %h expected %h", obs, exp_v);
    else pass_count++;
    scan_restart = 1'b0;
    tick();
    exp_v = {8'h13, 3'd3, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL restart_follow: got %h expected %h", obs, exp_v);
    else pass_count++;
    // Restart without a capture only reloads the pointer.
    scan_restart = 1'b1; sample = 1'b0;
    tick();
    exp_v = {8'h13, 3'd3, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL restart_idle: got %h expected %h", obs, exp_v);
    else pass_count++;
    scan_restart = 1'b0; sample = 1'b1;
    tick();
    exp_v = {8'h12, 3'd2, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL restart_idle_follow: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

  task automatic test_mode_reentry();
    // Manual capture of the scan_last channel must not raise scan_done.
    mode = 1'b0; sel = 3'd4; sample = 1'b1;
    tick();
    exp_v = {8'h14, 3'd4, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL reentry_manual: got %h expected %h", obs, exp_v);
    else pass_count++;
    mode = 1'b1;
    tick();
    exp_v = {8'h12, 3'd2, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL reentry_first: got %h expected %h", obs, exp_v);
    else pass_count++;
    tick();
    exp_v = {8'h13, 3'd3, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL reentry_second: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

  task automatic test_reset_mid_scan();
    reset_n = 1'b0; mode = 1'b1; sample = 1'b1;
    tick();
    exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL midscan_reset: got %h expected %h", obs, exp_v);
    else pass_count++;
    reset_n = 1'b1;
    tick();
    exp_v = {8'h12, 3'd2, 1'b1, 1'b0};
    check_count++;
    if (obs !== exp_v) $display("FAIL midscan_first: got %h expected %h", obs, exp_v);
    else pass_count++;
  endtask

`ifdef SCAN_MUX_PARITY_EN
  task automatic test_parity();
    mode = 1'b0; sample = 1'b1;
    data_in[0*WIDTH +: WIDTH] = 8'hA7;
    data_in[1*WIDTH +: WIDTH] = 8'h33;
    sel = 3'd0;
    tick();
    check_count++;
    if ({out, out_parity} !== {8'hA7, 1'b1})
      $display("FAIL parity_a7: got %h/%b expected a7/1", out, out_parity);
    else pass_count++;
    sel = 3'd1;
    tick();
    check_count++;
    if ({out, out_parity} !== {8'h33, 1'b0})
      $display("FAIL parity_33: got %h/%b expected 33/0", out, out_parity);
    else pass_count++;
    sample = 1'b0; sel = 3'd0;
    tick();
    check_count++;
    if ({out, out_parity} !== {8'h33, 1'b0})
      $display("FAIL parity_hold: got %h/%b expected 33/0", out, out_parity);
    else pass_count++;
    load_default_data();
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_back_to_back();
    test_scan_window();
    test_wrapped_window();
    test_window_change();
    test_restart();
    test_mode_reentry();
    test_reset_mid_scan();
`ifdef SCAN_MUX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
